vga_mode_ctrl: RTL

VGA_MODE_CTRL -- requirements
Module: vga_mode_ctrl

---
 rtl/vga_mode_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_mode_ctrl.sv
// Video mode controller: holds the timing table for the active mode and sequences a
// glitch-free switch (wait for frame boundary, pulse generator reset, acknowledge).
module vga_mode_ctrl #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4194303
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mode_sel,
    input  logic        mode_req,
    input  logic        vs_in,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_active_14,
    output logic [11:0] v_active_24,
    output logic [11:0] v_active_34,
    output logic        gen_reset_n,
    output logic [1:0]  pll_sel,
    output logic [2:0]  cur_mode,
    output logic        busy,
    output logic        mode_ack,
    output logic        mode_err
);

    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitVs = 2'd1,
        StHold   = 2'd2
    } state_e;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_start;
        logic [11:0] v_end;
        logic [11:0] v_active_14;
        logic [11:0] v_active_24;
        logic [11:0] v_active_34;
    } timing_t;

    // Quarter-frame lines are precomputed: v_start + (v_end - v_start) * k / 4.
    function automatic timing_t mode_timing(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd0: t = '{12'd799, 12'd95, 12'd141, 12'd781, 12'd524, 12'd1, 12'd34,
                        12'd514, 12'd154, 12'd274, 12'd394};
            2'd1: t = '{12'd1055, 12'd127, 12'd213, 12'd1013, 12'd627, 12'd3, 12'd26,
                        12'd626, 12'd176, 12'd326, 12'd476};
            2'd2: t = '{12'd1649, 12'd39, 12'd259, 12'd1539, 12'd749, 12'd4, 12'd24,
                        12'd744, 12'd204, 12'd384, 12'd564};
            default: t = '{12'd2199, 12'd43, 12'd189, 12'd2109, 12'd1124, 12'd4, 12'd40,
                           12'd1120, 12'd310, 12'd580, 12'd850};
        endcase
        return t;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  pending_q, pending_d;
    logic [1:0]  mode_q, mode_d;
    timing_t     timing_q, timing_d;
    logic [23:0] to_cnt_q, to_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        gen_reset_n_q, gen_reset_n_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        vs_d;
    logic        frame_start;

    assign frame_start = vs_d & ~vs_in;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        mode_d     = mode_q;
        timing_d   = timing_q;
        to_cnt_d   = to_cnt_q;
        hold_cnt_d = hold_cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mode_req) begin
                    if (mode_sel[2]) begin
                        err_d = 1'b1;
                    end else if (mode_sel[1:0] == mode_q) begin
                        ack_d = 1'b1;
                    end else begin
                        pending_d = mode_sel[1:0];
                        to_cnt_d  = '0;
                        state_d   = StWaitVs;
                    end
                end
            end
            StWaitVs: begin
                if (frame_start || to_cnt_q == TO_LAST) begin
                    state_d    = StHold;
                    mode_d     = pending_q;
                    timing_d   = mode_timing(pending_q);
                    hold_cnt_d = HOLD_LAST;
                end else begin
                    to_cnt_d = to_cnt_q + 24'd1;
                end
            end
            StHold: begin
                if (hold_cnt_q == 8'd0) begin
                    state_d = StIdle;
                    ack_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            default: state_d = StHold;
        endcase
        gen_reset_n_d = (state_d != StHold);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StHold;
            pending_q     <= 2'd0;
            mode_q        <= 2'd0;
            timing_q      <= mode_timing(2'd0);
            to_cnt_q      <= '0;
            hold_cnt_q    <= HOLD_LAST;
            gen_reset_n_q <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            vs_d          <= 1'b1;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            mode_q        <= mode_d;
            timing_q      <= timing_d;
            to_cnt_q      <= to_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            gen_reset_n_q <= gen_reset_n_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            vs_d          <= vs_in;
        end
    end

    assign h_total     = timing_q.h_total;
    assign h_sync      = timing_q.h_sync;
    assign h_start     = timing_q.h_start;
    assign h_end       = timing_q.h_end;
    assign v_total     = timing_q.v_total;
    assign v_sync      = timing_q.v_sync;
    assign v_start     = timing_q.v_start;
    assign v_end       = timing_q.v_end;
    assign v_active_14 = timing_q.v_active_14;
    assign v_active_24 = timing_q.v_active_24;
    assign v_active_34 = timing_q.v_active_34;
    assign gen_reset_n = gen_reset_n_q;
    assign pll_sel     = mode_q;
    assign cur_mode    = {1'b0, mode_q};
    assign busy        = (state_q != StIdle);
    assign mode_ack    = ack_q;
    assign mode_err    = err_q;

endmodule
